// File: rtl/pipelined_alu.sv
// pipelined_alu: valid/ready add/sub/select ALU with a STAGES-deep elastic pipeline
// and a wrapping count of delivered results.
module pipelined_alu #(
    parameter int WIDTH     = 16,
    parameter int STAGES    = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 carry,
    output logic [CNT_WIDTH-1:0] op_count
);
    logic [STAGES-1:0]          vld_q, vld_d, load;
    logic [STAGES-1:0][WIDTH:0] dat_q, dat_d;
    logic [STAGES:0]            vsrc;
    logic [STAGES:0][WIDTH:0]   dsrc;
    logic [WIDTH:0]             alu;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       accept, out_hs, full;

    // Top bit is carry-out for add and borrow for sub, since both use a zero-extended operation.
    always_comb begin
        alu = op == 2'b00 ? {1'b0, a} + {1'b0, b} :
              op == 2'b01 ? {1'b0, a} - {1'b0, b} :
              op == 2'b10 ? {1'b0, a} : {1'b0, b};
    end

    // A stage may load when any stage from it to the output is empty, or the output drains.
    always_comb begin
        full = 1'b1;
        load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full    = full & vld_q[k];
            load[k] = out_ready | !full;
        end
    end

    assign in_ready = !rst & load[0];
    assign accept   = in_valid & in_ready;
    assign out_hs   = vld_q[STAGES-1] & out_ready;
    assign vsrc     = {vld_q, accept};
    assign dsrc     = {dat_q, alu};

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = load[k] ? vsrc[k] : vld_q[k];
            dat_d[k] = load[k] ? dsrc[k] : dat_q[k];
        end
        cnt_d = cnt_q + CNT_WIDTH'(out_hs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign result    = dat_q[STAGES-1][WIDTH-1:0];
    assign carry     = dat_q[STAGES-1][WIDTH];
    assign op_count  = cnt_q;
endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: directed checks of latency, arithmetic, backpressure, reset and
// counter wrap across STAGES=1/2/4 and CNT_WIDTH=4 instances sharing one stimulus.
module tb_pipelined_alu;
    logic clk = 1'b0;
    logic rst, in_valid, out_ready;
    logic [15:0] a, b;
    logic [1:0] op;
    logic ir1, ov1, c1, ir2, ov2, c2, ir4, ov4, c4, irc, ovc, cc;
    logic [15:0] res1, res2, res4, resc, cnt1, cnt2, cnt4;
    logic [3:0] cntc;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_alu #(.WIDTH(16), .STAGES(1), .CNT_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b), .op(op),
        .out_valid(ov1), .out_ready(out_ready), .result(res1), .carry(c1), .op_count(cnt1));
    pipelined_alu #(.WIDTH(16), .STAGES(2), .CNT_WIDTH(16)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b), .op(op),
        .out_valid(ov2), .out_ready(out_ready), .result(res2), .carry(c2), .op_count(cnt2));
    pipelined_alu #(.WIDTH(16), .STAGES(4), .CNT_WIDTH(16)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .a(a), .b(b), .op(op),
        .out_valid(ov4), .out_ready(out_ready), .result(res4), .carry(c4), .op_count(cnt4));
    pipelined_alu #(.WIDTH(16), .STAGES(2), .CNT_WIDTH(4)) uc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irc), .a(a), .b(b), .op(op),
        .out_valid(ovc), .out_ready(out_ready), .result(resc), .carry(cc), .op_count(cntc));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", ir2, 0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    logic [15:0] va[6], vb[6], vr[6];
    logic [1:0]  vo[6];
    logic        vc[6];
    int i, j, hs;
    logic [3:0] exp_cnt;

    initial begin
        va = '{16'hFFFF, 16'h0005, 16'h1234, 16'h1234, 16'h0007, 16'h7FFF};
        vb = '{16'h0001, 16'h0007, 16'hABCD, 16'hABCD, 16'h0005, 16'h0001};
        vo = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
        vr = '{16'h0000, 16'hFFFE, 16'h1234, 16'hABCD, 16'h0002, 16'h8000};
        vc = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        a = '0; b = '0; op = '0;
        tick;
        do_reset;
        chk("rst_valid", ov2, 0);
        chk("rst_result", res2, 0);
        chk("rst_carry", c2, 0);
        chk("rst_count", cnt2, 0);
        #1;
        chk("ready_after_rst", ir2, 1);

        // single op: latency 1, 2 and 4 on the three depths
        in_valid = 1'b1; a = 16'd3; b = 16'd5; op = 2'b00;
        tick;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("lat1_valid", ov1, c == 0);
            chk("lat2_valid", ov2, c == 1);
            chk("lat4_valid", ov4, c == 3);
            chk("lat2_count", cnt2, c >= 2);
            if (c == 0) chk("lat1_result", {c1, res1}, 17'd8);
            if (c == 1) chk("lat2_result", {c2, res2}, 17'd8);
            if (c == 3) chk("lat4_result", {c4, res4}, 17'd8);
            tick;
        end

        // back-to-back arithmetic and select vectors
        for (int k = 0; k <= 6; k++) begin
            in_valid = k < 6;
            if (k < 6) begin
                a = va[k]; b = vb[k]; op = vo[k];
            end
            tick;
            if (k >= 1) begin
                chk("vec_valid", ov2, 1);
                chk("vec_result", res2, vr[k-1]);
                chk("vec_carry", c2, vc[k-1]);
            end
        end
        in_valid = 1'b0;
        tick;

        // backpressure: out_ready low for the first 5 cycles
        do_reset;
        i = 1; j = 1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = cyc >= 5;
            in_valid = i <= 6;
            a = 16'(i); b = 16'(i); op = 2'b00;
            #1;
            chk("bp_in_ready", ir2, out_ready || (i - j) < 2);
            chk("bp_valid", ov2, cyc >= 2 && j <= 6);
            if (ov2) chk("bp_result", res2, 32'(2 * j));
            if (ir2 && in_valid) i++;
            if (ov2 && out_ready) j++;
            tick;
        end
        in_valid = 1'b0;
        chk("bp_all_out", j, 7);
        chk("bp_count", cnt2, 6);

        // reset with two ops in flight
        out_ready = 1'b0;
        in_valid = 1'b1; a = 16'd9; b = 16'd9; op = 2'b00;
        tick;
        tick;
        in_valid = 1'b0;
        chk("mid_full", ov2, 1);
        rst = 1'b1;
        #1;
        chk("mid_in_ready", ir2, 0);
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mid_valid", ov2, 0);
        chk("mid_count", cnt2, 0);
        for (int c = 0; c < 5; c++) begin
            tick;
            chk("mid_no_ghost", ov2, 0);
        end

        // counter wrap on the 4-bit counter
        do_reset;
        hs = 0; exp_cnt = '0;
        for (int cyc = 0; cyc < 40 && hs < 17; cyc++) begin
            in_valid = 1'b1; a = 16'(cyc); b = '0; op = 2'b10;
            #1;
            chk("wrap_count", cntc, exp_cnt);
            if (ovc) begin
                hs++;
                exp_cnt = exp_cnt + 4'd1;
            end
            tick;
        end
        in_valid = 1'b0;
        chk("wrap_hs", hs, 17);
        chk("wrap_end", cntc, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
Parametrised, pipelined successor to the fixed 16-bit add/sub/mux demo blocks. Accepts an operand pair plus opcode per cycle over a valid/ready handshake. Computes add, subtract or select, and delivers the result after a configurable number of register stages with full backpressure. Keeps a running count of completed operations for the TUI to display.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)
STAGES, 2, pipeline depth in register stages (1..4)
CNT_WIDTH, 16, width of completed-operation counter

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair + op presented
in_ready  output  1  block can accept this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  2  00 add, 01 sub (a-b), 10 select a, 11 select b
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  computed value
carry  output  1  add: carry-out; sub: borrow (a<b unsigned); select: 0
op_count  output  CNT_WIDTH  number of output handshakes since reset

Behaviour:
- Reset is sampled on posedge clk with rst=1. It clears all stage valid bits, result=0, carry=0, op_count=0.
- in_ready=0 while rst=1. The first accept is possible on the cycle after rst falls.
- Input handshake: an accept occurs when in_valid & in_ready are both high at a posedge. Output handshake: out_valid & out_ready.
- Arithmetic: computed combinationally on the accept cycle and captured into stage 0 as a WIDTH+1 bit value.
  - add: {carry,result} = a+b, modulo 2^WIDTH with carry-out.
  - sub: result = a-b mod 2^WIDTH; carry = borrow.
  - select ops: carry=0.
- Stages 1..STAGES-1 are pure delay registers. result/carry/out_valid are driven directly from the last stage register, not combinationally from inputs.
- Latency: an op accepted at edge N has out_valid=1 after edge N+STAGES-1 (visible in the cycle following that edge), provided out_ready stayed 1.
- Stage advance rule: stage i loads from stage i-1 when stage i is empty or stage i is itself advancing. The last stage advances on an output handshake.
  - in_ready = stage0 empty | stage0 advancing. It is combinational from state and out_ready, with no path from in_valid.
- Throughput: one op per cycle sustained when out_ready=1.
- Backpressure: with out_ready=0 the pipeline fills. in_ready falls once all STAGES slots are occupied. No op is dropped, duplicated or reordered.
- Bubbles: in_valid=0 inserts a bubble. Bubbles collapse under backpressure; empty stages are filled.
- Held output: result/carry stay stable while out_valid=1 and out_ready=0.
- Simultaneous accept and output handshake on a full pipeline: both occur, and occupancy is unchanged.
- op_count increments by 1 on each output handshake and wraps from 2^CNT_WIDTH-1 to 0. The increment is visible the cycle after the handshake.
- Reset mid-operation: all in-flight ops are discarded without an output handshake, and op_count returns to 0.
- Undefined op values are impossible (2-bit op is fully decoded).

Test Plan:
- STAGES=2, out_ready=1: accept a=3,b=5,op=00 at edge 0 -> out_valid=1 with result=8, carry=0 after edge 1. op_count=1 the cycle after the handshake.
- Wrap/borrow: a=0xFFFF,b=0x0001,op=00 -> result=0x0000, carry=1. a=5,b=7,op=01 -> result=0xFFFE, carry=1.
- Select: a=0x1234,b=0xABCD, op=10 then op=11 back-to-back -> results 0x1234 then 0xABCD, carry=0, on consecutive cycles.
- Backpressure: stream 6 adds (i+i for i=1..6) with out_ready=0 for the first 5 cycles:
  - in_ready drops after 2 accepts (STAGES=2).
  - After release, results 2,4,6,8,10,12 emerge in order, one per cycle.
  - The held result stays stable while stalled; op_count ends at 6.
- Reset mid-flight: pulse rst=1 for one cycle with 2 ops in flight -> out_valid=0 and op_count=0 the next cycle, in_ready=0 during rst, and neither op ever appears.
- CNT_WIDTH=4: perform 17 output handshakes -> op_count sequence wraps 15 -> 0 and ends at 1. Repeat the latency check for STAGES=1 (result the cycle after accept) and STAGES=4.
